// File: rtl/readout_scheduler.sv
// Round-robin readout scheduler: grants one requester at a time and serializes
// its captured word as a START / ID / DATA frame on a single registered line.
module readout_scheduler #(
    parameter int WIDTH_INPUT = 128,
    parameter int NUM_REQ     = 4,
    parameter int ID_WIDTH    = 2
) (
    input  logic                           CLK,
    input  logic                           RST,
    input  logic                           EN,
    input  logic [NUM_REQ-1:0]             req,
    input  logic [NUM_REQ*WIDTH_INPUT-1:0] data_in,
    output logic [NUM_REQ-1:0]             ack,
    output logic                           data_out,
    output logic                           frame_active,
    output logic [ID_WIDTH-1:0]            cur_id,
    output logic [1:0]                     o_dbg_state
);

    localparam int CNT_W = (WIDTH_INPUT > 1) ? $clog2(WIDTH_INPUT) : 1;
    localparam logic [CNT_W-1:0] ID_LAST   = CNT_W'(ID_WIDTH - 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(WIDTH_INPUT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_ID    = 2'd2,
        S_DATA  = 2'd3
    } state_t;

    state_t                 r_state;
    logic [CNT_W-1:0]       r_cnt;
    logic [WIDTH_INPUT-1:0] r_shift;
    logic [ID_WIDTH-1:0]    r_id_sh;
    logic [ID_WIDTH-1:0]    r_cur_id;
    logic [ID_WIDTH-1:0]    r_ptr;
    logic [NUM_REQ-1:0]     r_ack;
    logic                   r_data_out;
    logic                   r_active;

    logic                   w_found;
    logic [ID_WIDTH-1:0]    w_grant;
    logic [WIDTH_INPUT-1:0] w_word;
    logic                   w_grant_pt;
    logic                   w_start;

    // Index wraps modulo NUM_REQ, so requesters >= NUM_REQ are never reachable.
    function automatic logic [ID_WIDTH-1:0] rr_index(input logic [ID_WIDTH-1:0] base,
                                                     input int off);
        int s;
        s = int'(base) + off;
        if (s >= NUM_REQ) s = s - NUM_REQ;
        return ID_WIDTH'(s);
    endfunction

    always_comb begin
        w_found = 1'b0;
        w_grant = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!w_found && req[rr_index(r_ptr, i)]) begin
                w_found = 1'b1;
                w_grant = rr_index(r_ptr, i);
            end
        end
        w_word = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (k == int'(w_grant)) w_word = data_in[k*WIDTH_INPUT +: WIDTH_INPUT];
        end
    end

    assign w_grant_pt = (r_state == S_IDLE) || ((r_state == S_DATA) && (r_cnt == DATA_LAST));
    assign w_start    = w_grant_pt && EN && w_found;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_shift    <= '0;
            r_id_sh    <= '0;
            r_cur_id   <= '0;
            r_ptr      <= '0;
            r_ack      <= '0;
            r_data_out <= 1'b0;
            r_active   <= 1'b0;
        end else begin
            r_ack <= '0;
            if (w_start) begin
                r_state    <= S_START;
                r_cnt      <= '0;
                r_shift    <= w_word;
                r_id_sh    <= w_grant;
                r_cur_id   <= w_grant;
                r_ptr      <= rr_index(w_grant, 1);
                r_ack      <= NUM_REQ'(1) << w_grant;
                r_data_out <= 1'b1;
                r_active   <= 1'b1;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        r_data_out <= 1'b0;
                        r_active   <= 1'b0;
                    end
                    S_START: begin
                        r_state    <= S_ID;
                        r_cnt      <= '0;
                        r_data_out <= r_id_sh[0];
                        r_id_sh    <= r_id_sh >> 1;
                    end
                    S_ID: begin
                        if (r_cnt == ID_LAST) begin
                            r_state    <= S_DATA;
                            r_cnt      <= '0;
                            r_data_out <= r_shift[0];
                            r_shift    <= r_shift >> 1;
                        end else begin
                            r_cnt      <= r_cnt + CNT_W'(1);
                            r_data_out <= r_id_sh[0];
                            r_id_sh    <= r_id_sh >> 1;
                        end
                    end
                    S_DATA: begin
                        // Last bit with no grant available: frame ends here.
                        if (r_cnt == DATA_LAST) begin
                            r_state    <= S_IDLE;
                            r_cnt      <= '0;
                            r_data_out <= 1'b0;
                            r_active   <= 1'b0;
                        end else begin
                            r_cnt      <= r_cnt + CNT_W'(1);
                            r_data_out <= r_shift[0];
                            r_shift    <= r_shift >> 1;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign ack          = r_ack;
    assign data_out     = r_data_out;
    assign frame_active = r_active;
    assign cur_id       = r_cur_id;
    assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_readout_scheduler.sv
// Bench for readout_scheduler: frame-level scoreboard fed by the drivers and
// drained by a serial monitor that deserializes each frame.
module tb_readout_scheduler;

    localparam int WIDTH     = 128;
    localparam int NREQ      = 4;
    localparam int IDW       = 2;
    localparam int FRAME_LEN = 1 + IDW + WIDTH;
    localparam int CW        = IDW + WIDTH;

    logic                    CLK = 1'b0;
    logic                    RST;
    logic                    EN;
    logic [NREQ-1:0]         req;
    logic [NREQ*WIDTH-1:0]   data_in;
    logic [NREQ-1:0]         ack;
    logic                    data_out;
    logic                    frame_active;
    logic [IDW-1:0]          cur_id;
    logic [1:0]              dbg_state;

    int n_tests = 0;
    int n_fail  = 0;
    logic [CW-1:0] exp_q[$];

    int run      = 0;
    int last_run = 0;
    int pos      = 0;
    logic [IDW-1:0]   got_id;
    logic [WIDTH-1:0] got_word;

    readout_scheduler #(.WIDTH_INPUT(WIDTH), .NUM_REQ(NREQ), .ID_WIDTH(IDW)) dut (
        .CLK(CLK), .RST(RST), .EN(EN), .req(req), .data_in(data_in),
        .ack(ack), .data_out(data_out), .frame_active(frame_active),
        .cur_id(cur_id), .o_dbg_state(dbg_state)
    );

    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input logic [CW-1:0] got, input logic [CW-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [WIDTH-1:0] rand_word();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic set_word(input int k, input logic [WIDTH-1:0] w);
        data_in[k*WIDTH +: WIDTH] = w;
    endtask

    task automatic push_frame(input logic [IDW-1:0] id, input logic [WIDTH-1:0] w);
        exp_q.push_back({id, w});
    endtask

    task automatic wait_ack(input int k, input int budget);
        logic got;
        got = 1'b0;
        for (int c = 0; c < budget; c++) begin
            if (ack[k]) begin
                got = 1'b1;
                break;
            end
            tick();
        end
        check_eq($sformatf("ack_wait_%0d", k), CW'(got), CW'(1));
    endtask

    task automatic wait_idle(input int budget);
        for (int c = 0; c < budget && frame_active; c++) tick();
        check_eq("idle_wait", CW'(frame_active), CW'(0));
        tick();
    endtask

    // Serial monitor: deserializes START/ID/DATA and compares with the scoreboard.
    initial begin : monitor
        logic [CW-1:0]   head;
        logic [NREQ-1:0] oh;
        forever begin
            @(negedge CLK);
            if (RST) begin
                pos = 0;
                run = 0;
            end else if (frame_active) begin
                run++;
                if (pos == 0) begin
                    check_eq("start_bit", CW'(data_out), CW'(1));
                    check_eq("frame_expected", CW'(exp_q.size() != 0), CW'(1));
                    if (exp_q.size() != 0) begin
                        head = exp_q[0];
                        oh = '0;
                        oh[head[CW-1 -: IDW]] = 1'b1;
                        check_eq("ack_onehot", CW'(ack), CW'(oh));
                        check_eq("cur_id", CW'(cur_id), CW'(head[CW-1 -: IDW]));
                    end
                end else if (pos <= IDW) begin
                    got_id[pos-1] = data_out;
                    if (pos == 1) check_eq("ack_one_cycle", CW'(ack), CW'(0));
                end else begin
                    got_word[pos-1-IDW] = data_out;
                end
                if (pos == FRAME_LEN - 1) begin
                    if (exp_q.size() != 0) begin
                        head = exp_q.pop_front();
                        check_eq("frame", {got_id, got_word}, head);
                    end
                    pos = 0;
                end else begin
                    pos++;
                end
            end else begin
                if (run != 0) last_run = run;
                run = 0;
                if (pos != 0) begin
                    check_eq("truncated", CW'(pos), CW'(0));
                    pos = 0;
                end
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        logic [WIDTH-1:0] w [NREQ];
        logic [WIDTH-1:0] a5;
        logic [WIDTH-1:0] ws;
        int bad;

        RST = 1'b1; EN = 1'b0; req = '0; data_in = '0;
        repeat (3) @(posedge CLK);
        #1;
        check_eq("rst_data_out", CW'(data_out), CW'(0));
        check_eq("rst_active", CW'(frame_active), CW'(0));
        check_eq("rst_ack", CW'(ack), CW'(0));
        check_eq("rst_cur_id", CW'(cur_id), CW'(0));
        check_eq("rst_state", CW'(dbg_state), CW'(0));
        RST = 1'b0;
        tick();
        check_eq("idle_quiet", CW'({frame_active, data_out}), CW'(0));

        // Round-robin from reset: 0,1,2,3,0 back-to-back.
        for (int k = 0; k < NREQ; k++) begin
            w[k] = rand_word();
            set_word(k, w[k]);
        end
        for (int n = 0; n < 5; n++) push_frame(IDW'(n % NREQ), w[n % NREQ]);
        req = 4'b1111;
        EN  = 1'b1;
        for (int n = 0; n < 5; n++) begin
            wait_ack(n % NREQ, 300);
            check_eq("rr_cur_id", CW'(cur_id), CW'(n % NREQ));
        end
        req = '0;
        wait_idle(300);
        check_eq("rr_no_gap_len", CW'(last_run), CW'(5 * FRAME_LEN));

        // Single request with the A5 pattern.
        a5 = {16{8'hA5}};
        set_word(0, a5);
        push_frame(IDW'(0), a5);
        req = 4'b0001;
        wait_ack(0, 20);
        req = '0;
        wait_idle(300);
        check_eq("single_len", CW'(last_run), CW'(FRAME_LEN));

        // EN gating: quiet while disabled, then requester 2 with ID bits 0,1.
        EN = 1'b0;
        w[2] = rand_word();
        set_word(2, w[2]);
        req = 4'b0100;
        bad = 0;
        for (int c = 0; c < 500; c++) begin
            tick();
            if (data_out !== 1'b0 || ack !== '0 || frame_active !== 1'b0) bad++;
        end
        check_eq("en_gate_quiet", CW'(bad), CW'(0));
        push_frame(IDW'(2), w[2]);
        EN = 1'b1;
        wait_ack(2, 20);
        check_eq("en_cur_id", CW'(cur_id), CW'(2));
        req = '0;
        wait_idle(300);

        // EN drops at DATA bit 40 with 0 and 1 still pending.
        w[0] = rand_word();
        set_word(0, w[0]);
        push_frame(IDW'(0), w[0]);
        req = 4'b0011;
        wait_ack(0, 20);
        repeat (1 + IDW + 40) tick();
        EN = 1'b0;
        wait_idle(300);
        check_eq("en_drop_len", CW'(last_run), CW'(FRAME_LEN));
        bad = 0;
        for (int c = 0; c < 300; c++) begin
            tick();
            if (frame_active !== 1'b0 || ack !== '0) bad++;
        end
        check_eq("en_drop_no_start", CW'(bad), CW'(0));
        req = '0;
        EN  = 1'b1;

        // Reset at DATA bit 60, then first grant restarts search at 0.
        w[2] = rand_word();
        set_word(2, w[2]);
        push_frame(IDW'(2), w[2]);
        req = 4'b0100;
        wait_ack(2, 20);
        req = '0;
        repeat (1 + IDW + 60) tick();
        check_eq("pre_rst_active", CW'(frame_active), CW'(1));
        #1;
        RST = 1'b1;
        #1;
        check_eq("async_rst_data_out", CW'(data_out), CW'(0));
        check_eq("async_rst_active", CW'(frame_active), CW'(0));
        check_eq("async_rst_ack", CW'(ack), CW'(0));
        exp_q.delete();
        tick();
        tick();
        check_eq("rst_mid_state", CW'(dbg_state), CW'(0));
        check_eq("rst_mid_cur_id", CW'(cur_id), CW'(0));
        w[1] = rand_word();
        w[3] = rand_word();
        set_word(1, w[1]);
        set_word(3, w[3]);
        push_frame(IDW'(1), w[1]);
        req = 4'b1010;
        RST = 1'b0;
        wait_ack(1, 20);
        check_eq("post_rst_grant", CW'(cur_id), CW'(1));
        req = '0;
        wait_idle(300);

        // Payload stays the captured word while data_in churns.
        ws = rand_word();
        set_word(0, ws);
        push_frame(IDW'(0), ws);
        req = 4'b0001;
        wait_ack(0, 20);
        req = '0;
        for (int c = 0; c < 300 && frame_active; c++) begin
            for (int k = 0; k < NREQ; k++) set_word(k, rand_word());
            tick();
        end
        wait_idle(50);

        check_eq("queue_empty", CW'(exp_q.size()), CW'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/readout_scheduler.md
READOUT_SCHEDULER -- requirements
Module: readout_scheduler

Interface
REQ-001 Parameter WIDTH_INPUT, default 128, SHALL set the payload bits per requester word.
REQ-002 Parameter NUM_REQ, default 4, SHALL set the number of requesters.
REQ-003 Parameter ID_WIDTH, default 2, SHALL set the channel-ID field width; NUM_REQ SHALL be at most 2**ID_WIDTH.
REQ-004 CLK  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-005 RST  input  1  SHALL be the reset: asynchronous, active-high.
REQ-006 EN  input  1  SHALL, when high, permit new frames to start.
REQ-007 req  input  NUM_REQ  SHALL carry the per-requester word-pending flags.
REQ-008 data_in  input  NUM_REQ*WIDTH_INPUT  SHALL carry the words; requester k occupies bits [k*WIDTH_INPUT +: WIDTH_INPUT].
REQ-009 ack  output  NUM_REQ  SHALL carry the per-requester one-cycle capture pulses.
REQ-010 data_out  output  1  SHALL be the registered serial stream.
REQ-011 frame_active  output  1  SHALL be high while a frame is being shifted out.
REQ-012 cur_id  output  ID_WIDTH  SHALL hold the ID of the requester whose frame is in flight.

Function
REQ-013 FSM states SHALL be IDLE, START, ID, DATA.
REQ-014 Frame format SHALL be: START (1 cycle, data_out=1), ID (ID_WIDTH cycles, cur_id LSB first), DATA (WIDTH_INPUT cycles, captured word LSB first); total length 1+ID_WIDTH+WIDTH_INPUT cycles.
REQ-015 IDLE SHALL drive data_out=0 and frame_active=0.
REQ-016 Grant decision points SHALL be (a) any edge while in IDLE and (b) the edge ending the last DATA bit.
REQ-017 At a grant point with EN=1 and req nonzero: the arbiter SHALL select a requester; the scheduler SHALL capture its data_in slice into the shift register, load cur_id, pulse ack[k] high for exactly the following cycle, and enter START.
REQ-018 At a grant point with EN=0 or req=0, the FSM SHALL enter or remain in IDLE.
REQ-019 Arbitration SHALL be round-robin: search begins at (last granted + 1) mod NUM_REQ; after reset, search begins at requester 0.
REQ-020 Back-to-back frames SHALL have no idle cycle: the last DATA bit SHALL be followed directly by the next START.
REQ-021 A requester SHALL drop or refresh req in the cycle after its ack; req values outside grant points SHALL be ignored.
REQ-022 EN falling mid-frame SHALL NOT truncate the frame; it SHALL complete, and IDLE SHALL follow.
REQ-023 data_in SHALL be sampled only at capture; later changes SHALL NOT affect the frame in flight.
REQ-024 frame_active SHALL be high in START, ID and DATA cycles, aligned with data_out.
REQ-025 The bit counter SHALL be sized clog2(WIDTH_INPUT) bits and SHALL reset to 0 on each state entry; no wrap SHALL occur inside a field.
REQ-026 Requester indices >= NUM_REQ SHALL never be granted.

Reset
REQ-027 While RST is high: state=IDLE, data_out=0, frame_active=0, ack=0, cur_id=0, shift register=0, round-robin pointer set so requester 0 has first priority.
REQ-028 Reset asserted mid-frame SHALL abort the frame immediately with no further ack; after release, the first grant SHALL follow REQ-019 from requester 0.

Verification
REQ-029 Single request: req=4'b0001, data_in slice 0 = 128'hA5A5...A5, EN=1 -> ack[0] pulses once; data_out = 1, 0, 0, then bits 1,0,1,0,0,1,0,1 repeated; frame_active high for 131 cycles, then IDLE.
REQ-030 Round-robin: req=4'b1111 held, ack handled per REQ-021 -> grant order 0,1,2,3,0 with cur_id matching; frames back-to-back with no gap.
REQ-031 EN gating: EN=0 with req=4'b0100 -> no ack and data_out=0 for 500 cycles; EN=1 -> ack[2] and a frame with ID bits 0,1.
REQ-032 EN drop mid-frame: EN cleared at DATA bit 40 with req=4'b0011 pending -> the current frame completes all 128 bits; no START follows.
REQ-033 Reset mid-frame: RST pulsed at DATA bit 60 -> data_out=0 and frame_active=0 asynchronously; with req=4'b1010 afterward, the first grant goes to requester 1.
REQ-034 Data stability: data_in changed every cycle after capture -> the serialized payload equals the word captured at the ack edge.
